// File: rtl/irq_flag_bank_if.sv
// CPU/peripheral-side bundle of the interrupt flag bank: control lines,
// read/deselect strobes, and the flag/lock/IRQ outputs.
interface irq_flag_bank_if #(
   parameter int NCH = 2
);
   // readp and deselect are single-cycle strobes with no ready/back-pressure:
   // readp opens a read (arms the clear), deselect closes it, and the bank
   // accepts each strobe on the clk edge where it is high.
   logic [NCH-1:0] ctrl_in;
   logic [NCH-1:0] edge_sel;
   logic [NCH-1:0] irq_en;
   logic           readp;
   logic           deselect;
   logic [NCH-1:0] flags;
   logic           locked;
   logic           irq_n;

   modport master (
      output ctrl_in, edge_sel, irq_en, readp, deselect,
      input  flags, locked, irq_n
   );

   modport slave (
      input  ctrl_in, edge_sel, irq_en, readp, deselect,
      output flags, locked, irq_n
   );
endinterface

// File: rtl/irq_flag_bank.sv
// NCH-channel PIA-style interrupt flags: edge-set flags, read/deselect clear
// that preserves edges arriving mid-read, and one combined active-low IRQ.
module irq_flag_bank #(
   parameter int NCH = 2
) (
   input  logic            clk,
   input  logic            nreset,
   irq_flag_bank_if.slave  bus
);

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } lock_state_e;

   lock_state_e    state_q, state_d;
   logic [NCH-1:0] flags_q, flags_d;
   logic [NCH-1:0] pending_q, pending_d;
   logic [NCH-1:0] snapshot_q, snapshot_d;
   logic [NCH-1:0] ctrl_d_q, ctrl_d_d;
   logic           primed_q, primed_d;
   logic [NCH-1:0] edge_det;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q    <= ST_UNLOCKED;
         flags_q    <= '0;
         pending_q  <= '0;
         snapshot_q <= '0;
         ctrl_d_q   <= '0;
         primed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         flags_q    <= flags_d;
         pending_q  <= pending_d;
         snapshot_q <= snapshot_d;
         ctrl_d_q   <= ctrl_d_d;
         primed_q   <= primed_d;
      end
   end

   // primed masks the first post-reset cycle, when ctrl_d_q holds the reset
   // zero rather than a real previous level.
   always_comb begin
      edge_det = '0;
      if (primed_q) begin
         edge_det = (bus.edge_sel & ~ctrl_d_q & bus.ctrl_in) |
                    (~bus.edge_sel & ctrl_d_q & ~bus.ctrl_in);
      end
   end

   always_comb begin
      state_d    = state_q;
      flags_d    = flags_q | edge_det;
      pending_d  = pending_q;
      snapshot_d = snapshot_q;
      ctrl_d_d   = bus.ctrl_in;
      primed_d   = 1'b1;

      case (state_q)
         ST_UNLOCKED: begin
            if (bus.readp) begin
               snapshot_d = flags_q;
               pending_d  = '0;
               state_d    = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            pending_d = pending_q | (edge_det & snapshot_q);
            // Snapshot channels clear to whatever arrived during the read.
            if (bus.deselect) begin
               flags_d    = (snapshot_q & (pending_q | edge_det)) |
                            (~snapshot_q & (flags_q | edge_det));
               snapshot_d = '0;
               pending_d  = '0;
               state_d    = ST_UNLOCKED;
            end
         end
         default: state_d = ST_UNLOCKED;
      endcase
   end

   assign bus.flags  = flags_q;
   assign bus.locked = (state_q == ST_LOCKED);
   assign bus.irq_n  = ~|(flags_q & bus.irq_en);

endmodule

// File: tb/tb_irq_flag_bank.sv
// Directed vector bench for irq_flag_bank with NCH=2.
module tb_irq_flag_bank;

   logic clk;
   logic nreset;
   int   checks;
   int   errors;

   irq_flag_bank_if #(.NCH(2)) bus ();

   irq_flag_bank #(.NCH(2)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst;
      logic [1:0] ci;
      logic [1:0] es;
      logic [1:0] en;
      logic       rp;
      logic       ds;
      logic [1:0] ef;
      logic       el;
      logic       ei;
   } vec_t;

   vec_t tbl[$];

   task automatic check_bits(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      nreset       = ~v.rst;
      bus.ctrl_in  = v.ci;
      bus.edge_sel = v.es;
      bus.irq_en   = v.en;
      bus.readp    = v.rp;
      bus.deselect = v.ds;
      @(posedge clk);
      #1;
      check_bits({v.name, ".flags"},  bus.flags,          v.ef);
      check_bits({v.name, ".locked"}, {1'b0, bus.locked}, {1'b0, v.el});
      check_bits({v.name, ".irq_n"},  {1'b0, bus.irq_n},  {1'b0, v.ei});
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      nreset       = 1'b0;
      bus.ctrl_in  = 2'b00;
      bus.edge_sel = 2'b00;
      bus.irq_en   = 2'b00;
      bus.readp    = 1'b0;
      bus.deselect = 1'b0;

      //            name      rst ci     es     en     rp    ds    ef     el    ei
      tbl.push_back('{"rst0",  1, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"rst1",  1, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"prime", 0, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"hold",  0, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"t2a",   0, 2'b00, 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"t2b",   0, 2'b01, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0});
      tbl.push_back('{"t2c",   0, 2'b11, 2'b11, 2'b01, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0});
      tbl.push_back('{"t2d",   0, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1});
      tbl.push_back('{"clrr",  0, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1});
      tbl.push_back('{"clrd",  0, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"t3a",   0, 2'b10, 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"t3b",   0, 2'b11, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0});
      tbl.push_back('{"t3rd",  0, 2'b11, 2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0});
      tbl.push_back('{"t3w1",  0, 2'b11, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0});
      tbl.push_back('{"t3w2",  0, 2'b11, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0});
      tbl.push_back('{"t3ds",  0, 2'b11, 2'b11, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"t4a",   0, 2'b10, 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"t4b",   0, 2'b11, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0});
      tbl.push_back('{"t4rd",  0, 2'b11, 2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0});
      tbl.push_back('{"t4f0",  0, 2'b10, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0});
      tbl.push_back('{"t4r0",  0, 2'b11, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0});
      tbl.push_back('{"t4ds",  0, 2'b11, 2'b11, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0});
      tbl.push_back('{"t4rd2", 0, 2'b11, 2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0});
      tbl.push_back('{"t4f1",  0, 2'b01, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0});
      tbl.push_back('{"t4r1",  0, 2'b11, 2'b11, 2'b01, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0});
      tbl.push_back('{"t4ds2", 0, 2'b11, 2'b11, 2'b01, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1});
      tbl.push_back('{"t5rd",  0, 2'b11, 2'b11, 2'b01, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1});
      tbl.push_back('{"t5ds",  0, 2'b11, 2'b11, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"t5es0", 0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"t5es1", 0, 2'b11, 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"t5es2", 0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"t5fal", 0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0});
      tbl.push_back('{"t5both",0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0});
      tbl.push_back('{"t5ds2", 0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1});
      tbl.push_back('{"t5c0",  0, 2'b01, 2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0});
      tbl.push_back('{"t5c1",  0, 2'b01, 2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0});
      tbl.push_back('{"t5coin",0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0});

      foreach (tbl[i]) apply(tbl[i]);

      // Reset asserted mid-lock, then the stale deselect and a fresh read.
      apply('{"t6set",   0, 2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0});
      apply('{"t6lock",  0, 2'b10, 2'b11, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0});
      apply('{"t6rst",   1, 2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1});
      apply('{"t6ds",    0, 2'b10, 2'b11, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1});
      apply('{"t6rd",    0, 2'b10, 2'b11, 2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1});
      apply('{"t6edge",  0, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0});
      apply('{"t6ds2",   0, 2'b11, 2'b11, 2'b11, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0});

      // irq_en acts on irq_n combinationally, without a clock edge.
      @(negedge clk);
      bus.irq_en = 2'b10;
      #1;
      check_bits("en_comb_off", {1'b0, bus.irq_n}, 2'b01);
      bus.irq_en = 2'b01;
      #1;
      check_bits("en_comb_on", {1'b0, bus.irq_n}, 2'b00);
      check_bits("en_keeps_flags", bus.flags, 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
